// File: rtl/tl_pkg.sv
// Lamp codes and request-state encoding shared by the farm car-request
// conditioner and the traffic-light FSM.
package tl_pkg;

    localparam logic [2:0] LAMP_RED = 3'b100;
    localparam logic [2:0] LAMP_YEL = 3'b010;
    localparam logic [2:0] LAMP_GRN = 3'b001;

    typedef enum logic [1:0] {
        REQ_IDLE    = 2'b00,
        REQ_PENDING = 2'b01,
        REQ_SERVING = 2'b10
    } req_state_t;

endpackage

// File: rtl/farm_car_request_sig_debounce.sv
// Two-flop synchroniser followed by a tick-qualified debouncer: the output
// level follows the synchronised input only after DEB_TICKS disagreeing ticks.
module sig_debounce
    import tl_pkg::*;
#(
    parameter int DEB_TICKS = 3
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_raw,
    input  logic i_tick,
    output logic o_level
);

    localparam int DW = (DEB_TICKS > 1) ? $clog2(DEB_TICKS) : 1;
    localparam logic [DW-1:0] DEB_LAST = DW'(DEB_TICKS - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_level;
    logic [DW-1:0] r_deb_cnt;

    // synchronise the asynchronous loop input
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
        end
    end

    // any agreeing tick restarts the run, so short glitches never flip the level
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_level   <= 1'b0;
            r_deb_cnt <= '0;
        end else if (i_tick) begin
            if (r_sync2 == r_level) begin
                r_deb_cnt <= '0;
            end else if (r_deb_cnt == DEB_LAST) begin
                r_level   <= r_sync2;
                r_deb_cnt <= '0;
            end else begin
                r_deb_cnt <= r_deb_cnt + DW'(1);
            end
        end
    end

    assign o_level = r_level;

endmodule

// File: rtl/farm_car_request.sv
// Farm-road car request conditioner: sample divider, debounced loop, request FSM
// and arrival counter. Define SENSOR_STUCK_EN to add the stuck-sensor fault monitor.
module farm_car_request
    import tl_pkg::*;
#(
    parameter int TICK_DIV    = 4,
    parameter int DEB_TICKS   = 3,
    parameter int WCNT_W      = 4,
    parameter int STUCK_TICKS = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sensor_raw,
    input  logic [2:0]        l_f,
    output logic              car_req,
    output logic              car_present,
    output logic [WCNT_W-1:0] wait_cnt,
    output logic              sensor_fault
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TW-1:0]     TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [WCNT_W-1:0] WAIT_MAX  = {WCNT_W{1'b1}};

    if (DEB_TICKS < 1 || STUCK_TICKS < 1) begin : g_bad_param
        $error("farm_car_request: DEB_TICKS and STUCK_TICKS must be >= 1");
    end

    logic [TW-1:0]     r_tick_cnt;
    logic              w_tick;
    logic              w_car_present;
    logic              r_car_present_d;
    logic              w_arrival;
    logic              w_fault;
    req_state_t        r_state;
    req_state_t        w_state_nxt;
    logic              r_rearm;
    logic              w_rearm_nxt;
    logic [WCNT_W-1:0] r_wait_cnt;
    logic [WCNT_W-1:0] w_wait_nxt;

    // free-running sample divider
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tick_cnt <= '0;
        end else if (w_tick) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + TW'(1);
        end
    end

    assign w_tick = (r_tick_cnt == TICK_LAST);

    sig_debounce #(
        .DEB_TICKS (DEB_TICKS)
    ) u_deb (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_raw   (sensor_raw),
        .i_tick  (w_tick),
        .o_level (w_car_present)
    );

    // delayed level for arrival edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_car_present_d <= 1'b0;
        end else begin
            r_car_present_d <= w_car_present;
        end
    end

    assign w_arrival = w_car_present & ~r_car_present_d;

`ifdef SENSOR_STUCK_EN
    localparam int SW = $clog2(STUCK_TICKS + 1);
    localparam logic [SW-1:0] STUCK_LIM = SW'(STUCK_TICKS);

    logic [SW-1:0] r_stuck_cnt;
    logic          r_fault;

    // a loop reporting a vehicle for too long is declared faulty until reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stuck_cnt <= '0;
            r_fault     <= 1'b0;
        end else begin
            if (!w_car_present) begin
                r_stuck_cnt <= '0;
            end else if (w_tick && (r_stuck_cnt != STUCK_LIM)) begin
                r_stuck_cnt <= r_stuck_cnt + SW'(1);
            end else begin
                r_stuck_cnt <= r_stuck_cnt;
            end
            if (r_stuck_cnt == STUCK_LIM) begin
                r_fault <= 1'b1;
            end else begin
                r_fault <= r_fault;
            end
        end
    end

    assign w_fault = r_fault;
`else
    assign w_fault = 1'b0;
`endif

    // request FSM next state; lamp codes other than red/green hold the state
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            REQ_IDLE: begin
                if (w_arrival) w_state_nxt = REQ_PENDING;
                else           w_state_nxt = REQ_IDLE;
            end
            REQ_PENDING: begin
                if (l_f == LAMP_GRN) w_state_nxt = REQ_SERVING;
                else                 w_state_nxt = REQ_PENDING;
            end
            REQ_SERVING: begin
                if (l_f == LAMP_RED)
                    w_state_nxt = (r_rearm | w_car_present) ? REQ_PENDING : REQ_IDLE;
                else
                    w_state_nxt = REQ_SERVING;
            end
            default: w_state_nxt = REQ_IDLE;
        endcase
        if (w_fault) w_state_nxt = REQ_IDLE;
        else         w_state_nxt = w_state_nxt;
    end

    // rearm and arrival count; clearing on SERVING entry beats a same-cycle arrival
    always_comb begin
        w_rearm_nxt = 1'b0;
        w_wait_nxt  = r_wait_cnt;
        if ((r_state == REQ_SERVING) && (w_state_nxt == REQ_SERVING))
            w_rearm_nxt = r_rearm | w_arrival;
        else
            w_rearm_nxt = 1'b0;
        if (w_fault)
            w_wait_nxt = '0;
        else if ((r_state != REQ_SERVING) && (w_state_nxt == REQ_SERVING))
            w_wait_nxt = '0;
        else if (w_arrival && (r_state != 2'b11) && (r_wait_cnt != WAIT_MAX))
            w_wait_nxt = r_wait_cnt + WCNT_W'(1);
        else
            w_wait_nxt = r_wait_cnt;
    end

    // FSM and counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= REQ_IDLE;
            r_rearm    <= 1'b0;
            r_wait_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_rearm    <= w_rearm_nxt;
            r_wait_cnt <= w_wait_nxt;
        end
    end

    assign car_req      = (r_state == REQ_PENDING);
    assign car_present  = w_car_present;
    assign wait_cnt     = r_wait_cnt;
    assign sensor_fault = w_fault;

endmodule

// File: tb/tb_farm_car_request.sv
// Directed self-checking bench for farm_car_request (TICK_DIV=4, DEB_TICKS=3, WCNT_W=4).
// The stuck-sensor section follows SENSOR_STUCK_EN.
module tb_farm_car_request;

    logic       clk = 1'b0;
    logic       rst;
    logic       sensor_raw;
    logic [2:0] l_f;
    logic       car_req;
    logic       car_present;
    logic [3:0] wait_cnt;
    logic       sensor_fault;

    int n_vec  = 0;
    int n_miss = 0;

    farm_car_request #(
        .TICK_DIV    (4),
        .DEB_TICKS   (3),
        .WCNT_W      (4),
        .STUCK_TICKS (64)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .sensor_raw   (sensor_raw),
        .l_f          (l_f),
        .car_req      (car_req),
        .car_present  (car_present),
        .wait_cnt     (wait_cnt),
        .sensor_fault (sensor_fault)
    );

    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic ncyc(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // wait (bounded) for car_present to reach the wanted level
    task automatic wait_present(input string tag, input logic want, input int budget);
        int n;
        n = 0;
        while ((car_present !== want) && (n < budget)) begin
            @(negedge clk);
            n++;
        end
        chk_eq(tag, 32'(car_present), 32'(want));
    endtask

    initial begin
        logic seen;
        rst        = 1'b1;
        sensor_raw = 1'b0;
        l_f        = 3'b100;
        ncyc(3);
        chk_eq("rst_car_req", 32'(car_req), 32'd0);
        chk_eq("rst_present", 32'(car_present), 32'd0);
        chk_eq("rst_wait", 32'(wait_cnt), 32'd0);
        chk_eq("rst_fault", 32'(sensor_fault), 32'd0);
        rst = 1'b0;
        ncyc(2);

        // 1: 5-clk glitch must be rejected
        sensor_raw = 1'b1;
        ncyc(5);
        sensor_raw = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            seen = seen | car_present | car_req | (wait_cnt != 4'd0);
        end
        chk_eq("glitch_reject", 32'(seen), 32'd0);

        // 2: held sensor -> present within 18 clk, request next clk
        sensor_raw = 1'b1;
        wait_present("t2_present_18clk", 1'b1, 18);
        @(negedge clk);
        chk_eq("t2_car_req", 32'(car_req), 32'd1);
        chk_eq("t2_wait", 32'(wait_cnt), 32'd1);

        // 3: green serves the request, then red with no car returns to idle
        l_f = 3'b001;
        @(negedge clk);
        chk_eq("t3_req_drop", 32'(car_req), 32'd0);
        chk_eq("t3_wait_clr", 32'(wait_cnt), 32'd0);
        sensor_raw = 1'b0;
        wait_present("t3_absent", 1'b0, 30);
        l_f = 3'b100;
        ncyc(4);
        chk_eq("t3_idle_req", 32'(car_req), 32'd0);

        // 4: arrival during SERVING re-requests at red
        sensor_raw = 1'b1;
        wait_present("t4_present", 1'b1, 20);
        @(negedge clk);
        chk_eq("t4_req", 32'(car_req), 32'd1);
        l_f = 3'b001;
        @(negedge clk);
        chk_eq("t4_serving", 32'(car_req), 32'd0);
        sensor_raw = 1'b0;
        ncyc(24);
        chk_eq("t4_low", 32'(car_present), 32'd0);
        sensor_raw = 1'b1;
        ncyc(24);
        chk_eq("t4_high", 32'(car_present), 32'd1);
        chk_eq("t4_no_req_in_serv", 32'(car_req), 32'd0);
        chk_eq("t4_wait_serv", 32'(wait_cnt), 32'd1);
        sensor_raw = 1'b0;
        ncyc(24);
        chk_eq("t4_low2", 32'(car_present), 32'd0);
        l_f = 3'b100;
        @(negedge clk);
        chk_eq("t4_rearm_req", 32'(car_req), 32'd1);

        // 5: 20 arrivals saturate the counter at 15
        for (int k = 0; k < 20; k++) begin
            sensor_raw = 1'b1;
            ncyc(24);
            sensor_raw = 1'b0;
            ncyc(24);
        end
        chk_eq("t5_wait_sat", 32'(wait_cnt), 32'd15);
        chk_eq("t5_req_held", 32'(car_req), 32'd1);
        l_f = 3'b011;
        ncyc(4);
        chk_eq("t5_lamp011", 32'(car_req), 32'd1);
        l_f = 3'b000;
        ncyc(4);
        chk_eq("t5_lamp000", 32'(car_req), 32'd1);
        l_f = 3'b100;
        sensor_raw = 1'b1;
        ncyc(24);
        chk_eq("t5_wait_still_sat", 32'(wait_cnt), 32'd15);
        rst = 1'b1;
        #1;
        chk_eq("t5_async_req", 32'(car_req), 32'd0);
        chk_eq("t5_async_present", 32'(car_present), 32'd0);
        chk_eq("t5_async_wait", 32'(wait_cnt), 32'd0);
        chk_eq("t5_async_fault", 32'(sensor_fault), 32'd0);
        ncyc(3);
        rst = 1'b0;
        ncyc(2);
        chk_eq("t5_fresh_deb", 32'(car_present), 32'd0);
        wait_present("t5_present_again", 1'b1, 20);
        @(negedge clk);
        chk_eq("t5_rereq", 32'(car_req), 32'd1);
        chk_eq("t5_rewait", 32'(wait_cnt), 32'd1);

        // 6: long-held sensor
        ncyc(300);
`ifdef SENSOR_STUCK_EN
        chk_eq("t6_fault", 32'(sensor_fault), 32'd1);
        chk_eq("t6_fault_req", 32'(car_req), 32'd0);
        chk_eq("t6_fault_wait", 32'(wait_cnt), 32'd0);
        sensor_raw = 1'b0;
        ncyc(40);
        chk_eq("t6_sticky", 32'(sensor_fault), 32'd1);
        rst = 1'b1;
        #1;
        chk_eq("t6_rst_clear", 32'(sensor_fault), 32'd0);
        ncyc(2);
        rst = 1'b0;
`else
        chk_eq("t6_no_fault", 32'(sensor_fault), 32'd0);
        chk_eq("t6_req_kept", 32'(car_req), 32'd1);
`endif
        ncyc(2);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
